// File: rtl/fc_layer_cu.sv
// Control unit for one fully-connected LeNet5 layer: it accepts the input elements, sequences the weight reads and MAC enables, injects the bias, drains the results and hands off to the next layer.
// Optional FC_RELU_EN: when defined, relu_en follows out_we during DRAIN; otherwise relu_en is tied low.
module fc_layer_cu #(
  parameter int unsigned IFM_DEPTH   = 120,
  parameter int unsigned NUM_NEURONS = 84,
  parameter int unsigned MAC_LAT     = 2,
  parameter int unsigned ADDR_W      = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1,
  parameter int unsigned OUT_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_wm_enable_read,
  output logic [ADDR_W-1:0] o_wm_addr,
  output logic              o_acc_clear,
  output logic              o_mac_en,
  output logic              o_bias_sel,
  output logic              o_out_we,
  output logic [OUT_W-1:0]  o_out_addr,
  output logic              o_relu_en,
  output logic              o_start_to_next,
  input  logic              i_end_from_next,
  output logic              o_busy
);

  localparam int unsigned FLUSH_W = 3;
  localparam logic [ADDR_W-1:0]  IN_LAST    = ADDR_W'(IFM_DEPTH - 1);
  localparam logic [OUT_W-1:0]   OUT_LAST   = OUT_W'(NUM_NEURONS - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_BIAS,
    S_DRAIN,
    S_NOTIFY,
    S_WAIT
  } state_t;

  // With no MAC latency the pipeline is already empty after the last element.
  localparam state_t S_AFTER_ACC = (MAC_LAT == 0) ? S_BIAS : S_FLUSH;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_in_cnt;
  logic [OUT_W-1:0]    r_out_cnt;
  logic [FLUSH_W-1:0]  r_flush_cnt;

  logic w_in_ready;
  logic w_hs;
  logic w_in_last;
  logic w_out_last;
  logic w_flush_last;
  logic w_acc_clear;
  logic w_bias_sel;
  logic w_out_we;
  logic w_start;
  logic w_mac_en;

  assign w_in_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign w_hs         = i_in_valid & w_in_ready;
  assign w_in_last    = (r_in_cnt == IN_LAST);
  assign w_out_last   = (r_out_cnt == OUT_LAST);
  assign w_flush_last = (r_flush_cnt == FLUSH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_acc_clear = 1'b0;
    w_bias_sel  = 1'b0;
    w_out_we    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc_clear = 1'b1;
        if (w_hs) begin
          w_next = w_in_last ? S_AFTER_ACC : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_hs && w_in_last) begin
          w_next = S_AFTER_ACC;
        end
      end
      S_FLUSH: begin
        if (w_flush_last) begin
          w_next = S_BIAS;
        end
      end
      S_BIAS: begin
        w_bias_sel = 1'b1;
        w_next     = S_DRAIN;
      end
      S_DRAIN: begin
        w_out_we = 1'b1;
        if (w_out_last) begin
          w_next = S_NOTIFY;
        end
      end
      S_NOTIFY: begin
        w_start = 1'b1;
        w_next  = i_end_from_next ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (i_end_from_next) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Element index: advances only on accepted handshakes, wraps after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_cnt <= '0;
    end else if (w_hs) begin
      r_in_cnt <= w_in_last ? '0 : r_in_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (r_state == S_FLUSH) begin
      r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + FLUSH_W'(1);
    end else begin
      r_flush_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_cnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_out_cnt <= w_out_last ? '0 : r_out_cnt + OUT_W'(1);
    end
  end

  // MAC enable trails each handshake by the weight-read latency.
  generate
    if (MAC_LAT == 0) begin : g_mac_comb
      assign w_mac_en = w_hs;
    end else begin : g_mac_pipe
      logic [MAC_LAT-1:0] r_mac_pipe;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_mac_pipe <= '0;
        end else begin
          r_mac_pipe[0] <= w_hs;
          for (int i = 1; i < MAC_LAT; i++) begin
            r_mac_pipe[i] <= r_mac_pipe[i-1];
          end
        end
      end
      assign w_mac_en = r_mac_pipe[MAC_LAT-1];
    end
  endgenerate

  assign o_in_ready       = w_in_ready;
  assign o_wm_enable_read = w_hs;
  assign o_wm_addr        = w_hs ? r_in_cnt : '0;
  assign o_acc_clear      = w_acc_clear;
  assign o_mac_en         = w_mac_en;
  assign o_bias_sel       = w_bias_sel;
  assign o_out_we         = w_out_we;
  assign o_out_addr       = r_out_cnt;
  assign o_start_to_next  = w_start;
  assign o_busy           = (r_state != S_IDLE);

`ifdef FC_RELU_EN
  assign o_relu_en = w_out_we;
`else
  assign o_relu_en = 1'b0;
`endif

endmodule

// File: tb/tb_fc_layer_cu.sv
// Directed bench for fc_layer_cu: default 120/84/2 instance plus a 1/10/0 corner instance.
module tb_fc_layer_cu;

  localparam int IFM = 120;
  localparam int NN  = 84;
  localparam int LAT = 2;

  logic clk;
  logic reset;

  logic       in_valid, end_from_next;
  logic       in_ready, wm_en, acc_clear, mac_en, bias_sel, out_we, relu_en, start_to_next, busy;
  logic [6:0] wm_addr, out_addr;

  logic       s_in_valid, s_end_from_next;
  logic       s_in_ready, s_wm_en, s_acc_clear, s_mac_en, s_bias_sel, s_out_we, s_relu_en, s_start, s_busy;
  logic [0:0] s_wm_addr;
  logic [3:0] s_out_addr;

  int n_cmp = 0;
  int n_bad = 0;

  fc_layer_cu #(.IFM_DEPTH(IFM), .NUM_NEURONS(NN), .MAC_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_wm_enable_read(wm_en), .o_wm_addr(wm_addr),
    .o_acc_clear(acc_clear), .o_mac_en(mac_en), .o_bias_sel(bias_sel),
    .o_out_we(out_we), .o_out_addr(out_addr), .o_relu_en(relu_en),
    .o_start_to_next(start_to_next), .i_end_from_next(end_from_next), .o_busy(busy)
  );

  fc_layer_cu #(.IFM_DEPTH(1), .NUM_NEURONS(10), .MAC_LAT(0)) dut_s (
    .clk(clk), .reset(reset),
    .i_in_valid(s_in_valid), .o_in_ready(s_in_ready),
    .o_wm_enable_read(s_wm_en), .o_wm_addr(s_wm_addr),
    .o_acc_clear(s_acc_clear), .o_mac_en(s_mac_en), .o_bias_sel(s_bias_sel),
    .o_out_we(s_out_we), .o_out_addr(s_out_addr), .o_relu_en(s_relu_en),
    .o_start_to_next(s_start), .i_end_from_next(s_end_from_next), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected output bundle; relu_en follows out_we only when the feature is built in.
  function automatic logic [31:0] pk(input logic rdy, input logic wen, input int waddr,
                                     input logic clr, input logic mac, input logic bias,
                                     input logic we, input int oaddr, input logic st,
                                     input logic bsy);
    logic relu;
`ifdef FC_RELU_EN
    relu = we;
`else
    relu = 1'b0;
`endif
    return {7'd0, rdy, wen, 8'(waddr), clr, mac, bias, we, 8'(oaddr), st, bsy, relu};
  endfunction

  function automatic logic [31:0] obs_main();
    return {7'd0, in_ready, wm_en, 8'(wm_addr), acc_clear, mac_en, bias_sel, out_we,
            8'(out_addr), start_to_next, busy, relu_en};
  endfunction

  function automatic logic [31:0] obs_sw();
    return {7'd0, s_in_ready, s_wm_en, 8'(s_wm_addr), s_acc_clear, s_mac_en, s_bias_sel,
            s_out_we, 8'(s_out_addr), s_start, s_busy, s_relu_en};
  endfunction

  // Timeline of a stream whose handshakes fall every 'stride' cycles from cycle 0, last at T.
  function automatic logic [31:0] exp_main(input int c, input int stride, input int t,
                                           input logic iv);
    logic hs, mac, we;
    hs  = iv && (c <= t);
    mac = (c >= LAT) && (c - LAT <= t) && ((c - LAT) % stride == 0);
    we  = (c >= t + LAT + 2) && (c <= t + LAT + 1 + NN);
    return pk(c <= t, hs, hs ? c / stride : 0, c == 0, mac, c == t + LAT + 1,
              we, we ? c - (t + LAT + 2) : 0, c == t + LAT + 2 + NN, c != 0);
  endfunction

  task automatic run_stream(input int stride, input logic bp, input logic endv);
    int t;
    t = stride * (IFM - 1);
    for (int c = 0; c <= t + LAT + 2 + NN; c++) begin
      @(negedge clk);
      in_valid      = (c <= t) ? (c % stride == 0) : bp;
      end_from_next = endv;
      #1 check_eq($sformatf("s%0d_c%0d", stride, c), obs_main(), exp_main(c, stride, t, in_valid));
    end
  endtask

  initial begin
    logic [31:0] idle_v, wait_v;
    idle_v = pk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    wait_v = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    in_valid = 1'b0;
    end_from_next = 1'b0;
    s_in_valid = 1'b0;
    s_end_from_next = 1'b0;

    repeat (2) @(negedge clk);
    #1 check_eq("rst_main", obs_main(), idle_v);
    check_eq("rst_sweep", obs_sw(), idle_v);
    reset = 1'b0;

    // Continuous stream; end_from_next held high must be ignored until NOTIFY.
    run_stream(1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    end_from_next = 1'b0;
    #1 check_eq("cont_idle", obs_main(), idle_v);

    // Gapped stream with in_valid held high once the last element is taken.
    run_stream(3, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1 check_eq($sformatf("wait_%0d", i), obs_main(), wait_v);
    end
    @(negedge clk);
    in_valid = 1'b0;
    end_from_next = 1'b1;
    #1 check_eq("wait_end", obs_main(), wait_v);
    @(negedge clk);
    end_from_next = 1'b0;
    #1 check_eq("gap_idle", obs_main(), idle_v);

    // Abort after 50 handshakes with an asynchronous reset.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1 check_eq($sformatf("pre_rst_c%0d", c), obs_main(), exp_main(c, 1, IFM - 1, 1'b1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_eq("async_rst", obs_main(), idle_v);
    @(negedge clk);
    reset = 1'b0;
    run_stream(1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    end_from_next = 1'b0;
    #1 check_eq("post_rst_idle", obs_main(), idle_v);

    // Single-element, zero-latency, ten-neuron instance.
    @(negedge clk);
    s_in_valid = 1'b1;
    #1 check_eq("sw_hs", obs_sw(), pk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 check_eq("sw_bias", obs_sw(), pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 check_eq($sformatf("sw_drain%0d", c), obs_sw(), pk(0, 0, 0, 0, 0, 0, 1, c, 0, 1));
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    s_end_from_next = 1'b1;
    #1 check_eq("sw_notify", obs_sw(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    @(negedge clk);
    s_end_from_next = 1'b0;
    #1 check_eq("sw_idle", obs_sw(), idle_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_cu.md
Name: fc_layer_cu

Overview:
Generic control unit for one fully-connected layer of the LeNet5 pipeline, parametrised in input depth, output neuron count and MAC read latency.
- Accepts IFM_DEPTH input elements from the previous layer via valid/ready, one element per handshake.
- Sequences weight reads and MAC enables for all neurons in parallel, then injects bias.
- Drains NUM_NEURONS results into the next layer's input memory, then hands off with a start/end handshake.

Parameters:
IFM_DEPTH, 120, number of input elements per inference
NUM_NEURONS, 84, number of output neurons / results drained
MAC_LAT, 2, cycles from weight read enable to the data valid at the MAC (0..7)
ADDR_W, $clog2(IFM_DEPTH), weight address width
OUT_W, $clog2(NUM_NEURONS), output address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  previous layer presents an input element
in_ready  out  1  block accepts an element this cycle
wm_enable_read  out  1  weight memory read enable
wm_addr  out  ADDR_W  weight row = index of the accepted element
acc_clear  out  1  hold MAC accumulators at zero
mac_en  out  1  accumulate product this cycle
bias_sel  out  1  add bias into accumulators this cycle
out_we  out  1  write one result to the next layer's memory
out_addr  out  OUT_W  result index / next-layer write address
relu_en  out  1  apply ReLU on the written result (optional feature)
start_to_next  out  1  one-cycle pulse: results complete
end_from_next  in  1  next layer has finished with the buffer
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ACCUM, FLUSH, BIAS, DRAIN, NOTIFY, WAIT.
- Reset (asynchronous): state=IDLE; all counters 0; mac_en pipe cleared; all outputs 0 except in_ready=1 and acc_clear=1, which follow the IDLE decode.
- Handshake:
  - hs = in_valid & in_ready.
  - in_ready=1 only in IDLE and ACCUM.
  - On hs: wm_enable_read=1 and wm_addr=in_cnt, both combinational in the same cycle; in_cnt increments.
- mac_en equals hs delayed by exactly MAC_LAT cycles (shift register). With MAC_LAT=0, mac_en=hs.
- IDLE:
  - acc_clear=1.
  - hs -> ACCUM, with the element counted as index 0.
  - If IFM_DEPTH=1, go directly to FLUSH, or to BIAS when MAC_LAT=0.
- ACCUM:
  - in_valid gaps allowed; only handshakes count.
  - hs while in_cnt==IFM_DEPTH-1 -> FLUSH (BIAS if MAC_LAT=0); in_cnt returns to 0.
- FLUSH: exactly MAC_LAT cycles, so the last mac_en falls in the final FLUSH cycle; then -> BIAS.
- BIAS: one cycle, bias_sel=1 -> DRAIN.
- DRAIN:
  - NUM_NEURONS cycles, out_we=1, out_addr=0..NUM_NEURONS-1 ascending.
  - After out_addr==NUM_NEURONS-1: -> NOTIFY, out_addr returns to 0.
- NOTIFY: start_to_next=1 for one cycle.
  - If end_from_next=1 in this cycle -> IDLE.
  - Otherwise -> WAIT.
- WAIT: hold until end_from_next=1 -> IDLE. in_ready=0 throughout.
- Timing: for a last handshake at cycle T, BIAS is at T+MAC_LAT+1 and the first out_we at T+MAC_LAT+2.
- in_valid outside IDLE/ACCUM is ignored; no element is lost because in_ready=0.
- end_from_next outside NOTIFY/WAIT is ignored.
- Reset mid-operation aborts immediately; the next inference restarts at wm_addr 0.

Optional Feature:
FC_RELU_EN
- Defined: relu_en = out_we (high exactly during DRAIN writes).
- Undefined: relu_en tied 0; the port stays present so top-level wiring is unchanged.

Test Plan:
- Reset, defaults (120/84/2): in_ready=1, acc_clear=1, busy=0, all other outputs 0, state IDLE.
- Continuous stream, 120 valids from cycle 0:
  - wm_addr 0..119 on cycles 0..119; mac_en high on cycles 2..121.
  - bias_sel at cycle 122; out_we cycles 123..206 with out_addr 0..83.
  - start_to_next single pulse at 207.
- Gapped stream, in_valid 1-of-3 cycles: exactly 120 handshakes, wm_addr increments only on handshakes, and mac_en pulses mirror those handshakes 2 cycles later.
- Back-pressure: in_valid held high during FLUSH/BIAS/DRAIN/WAIT -> in_ready=0 and no wm_enable_read; end_from_next held low 50 cycles after NOTIFY -> stays WAIT; pulse it -> IDLE next cycle, in_ready=1.
- Reset asserted after 50 handshakes: everything returns to defaults asynchronously; the next stream starts at wm_addr=0 and completes normally.
- Parameter and macro sweep:
  - IFM_DEPTH=1, MAC_LAT=0, NUM_NEURONS=10: BIAS in the cycle after the single handshake, 10 writes.
  - With FC_RELU_EN defined: relu_en==out_we on every cycle.
